branch_prediction_control: RTL
==============================

Name: branch_prediction_control

Overview:
Control/sequencing block for the BTB + 2-bit predictor datapath.
- Computes the next 2-bit saturating-counter value written back at MEM.
- Qualifies predictor writes with MEM-stage validity.
- Runs an invalidate-sweep FSM that clears every BTB/prediction entry after reset or on a flush request, stalling fetch meanwhile.
- Raises the pipeline flush on misprediction and keeps branch/mispredict performance counters.

Parameters:
s_index, 10, BTB index width; array depth = 2**s_index
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  system clock
rst  in  1  reset
flush_req  in  1  request to invalidate the whole BTB (e.g. fence.i)
mem_valid  in  1  MEM stage holds a real, non-stalled instruction
mem_is_branch  in  1  MEM instruction is branch, jal or jalr
mem_BTB_hit  in  1  MEM instruction hit in BTB at fetch
mem_actual_branch_outcome  in  1  1 = taken
mem_predicted_branch_outcome  in  2  counter value read at fetch
mem_misprediction  in  1  misprediction flag from datapath
mem_updated_prediction  out  2  counter value to write
pred_update_en  out  1  write enable for the prediction/BTB arrays
sweep_active  out  1  invalidate sweep in progress
sweep_index  out  s_index  array index being cleared
sweep_we  out  1  clear-write strobe at sweep_index
stall_if  out  1  hold PC/IF
flush_pipe  out  1  kill IF/ID/EX contents
branch_count  out  CNT_W  retired control-flow instructions
mispredict_count  out  CNT_W  retired mispredictions

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: FSM = SWEEP, sweep_index = 0, both counters = 0. Outputs during/after reset follow the SWEEP equations: sweep_active = 1, sweep_we = 1, stall_if = 1, pred_update_en = 0, flush_pipe = 0, mem_updated_prediction = 2'b00.
- FSM states: SWEEP, RUN.
- SWEEP state:
  - Each cycle: sweep_we = 1 at sweep_index, then sweep_index increments.
  - When sweep_index == 2**s_index-1, the next state is RUN and sweep_index wraps to 0.
  - A full sweep takes exactly 2**s_index cycles.
  - stall_if = 1, pred_update_en = 0, flush_pipe = 0, counters frozen.
  - flush_req during SWEEP restarts the sweep: sweep_index is 0 in the next cycle.
- RUN state:
  - flush_req = 1 causes the next state to be SWEEP with sweep_index = 0.
  - The current-cycle MEM update still completes.
- Update enable: pred_update_en = RUN & mem_valid & (mem_is_branch | mem_BTB_hit). Combinational, same cycle.
- Counter update (combinational), with p = mem_predicted_branch_outcome and t = mem_actual_branch_outcome:
  - BTB hit: t=1 gives min(p+1, 3); t=0 gives max(p-1, 0).
  - BTB miss and branch: t=1 gives 2'b10 (weakly taken); t=0 gives 2'b01.
  - Otherwise: 2'b00.
- flush_pipe = RUN & mem_valid & mem_misprediction. Combinational, same cycle as the datapath redirect.
- Performance counters (RUN only, registered, +1 per qualifying cycle, saturate at all-ones with no wrap):
  - branch_count increments when mem_valid & mem_is_branch.
  - mispredict_count increments when flush_pipe.
- Simultaneous events:
  - Misprediction and flush_req in the same cycle: flush_pipe = 1, counters update, SWEEP starts next cycle.
  - mem_valid = 0 suppresses every update, flush and count.
- Reset mid-sweep: async return to the reset state; the sweep restarts at index 0.
- Invariant: mem_misprediction & mem_valid never occurs in SWEEP. The bench asserts this; the RTL ignores it.

Decomposition:
- Shared package rv32i_types gets:
  - bp_state_t enum {BP_SWEEP, BP_RUN}
  - constants BP_WEAK_TAKEN = 2'b10, BP_WEAK_NT = 2'b01
- Sub-module sat_counter2: the pure combinational 2-bit saturating next-value function.
- Performance counters stay inline.

Test Plan:
- Reset then release, s_index = 4 -> sweep_we high for exactly 16 cycles, sweep_index 0..15, then sweep_active = 0 and stall_if = 0 in cycle 17.
- RUN, hit, p = 3, t = 1 -> mem_updated_prediction = 3. Hit, p = 0, t = 0 -> 0. Hit, p = 2, t = 0 -> 1. Miss branch t = 1 -> 2. Miss branch t = 0 -> 1.
- RUN, mem_valid = 1, mem_misprediction = 1 -> flush_pipe = 1 same cycle, mispredict_count +1 next cycle. Same with mem_valid = 0 -> no flush, no count.
- flush_req in RUN at the same cycle as a misprediction -> flush_pipe = 1, counts update, next cycle SWEEP with sweep_index = 0 and pred_update_en = 0.
- flush_req at sweep_index = 7 (s_index = 4) -> next sweep_index = 0, total sweep extends to 16 more cycles.
- Preload branch_count = 2**CNT_W-1 (CNT_W = 4), issue a branch -> stays 15. Assert rst mid-sweep -> sweep_index = 0 immediately, counters = 0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types and constants for the branch predictor control path.
package rv32i_types;

  typedef enum logic {
    BP_SWEEP,
    BP_RUN
  } bp_state_t;

  // Initial counter values for a branch seen for the first time
  localparam logic [1:0] BP_WEAK_TAKEN = 2'b10;
  localparam logic [1:0] BP_WEAK_NT    = 2'b01;

endpackage

// File: rtl/sat_counter2.sv
// Next value of a 2-bit saturating branch counter.
module sat_counter2 (
  input  logic [1:0] cnt_in,
  input  logic       taken,
  output logic [1:0] cnt_out
);

  always_comb begin
    cnt_out = cnt_in;
    if (taken) begin
      if (cnt_in != 2'b11) cnt_out = cnt_in + 2'd1;
    end else begin
      if (cnt_in != 2'b00) cnt_out = cnt_in - 2'd1;
    end
  end

endmodule

// File: rtl/branch_prediction_control.sv
// Sequencing for the BTB/2-bit predictor: counter update, write qualification,
// invalidate sweep after reset or flush, mispredict flush and perf counters.
module branch_prediction_control
  import rv32i_types::*;
#(
  parameter int s_index = 10,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_req,
  input  logic               mem_valid,
  input  logic               mem_is_branch,
  input  logic               mem_BTB_hit,
  input  logic               mem_actual_branch_outcome,
  input  logic [1:0]         mem_predicted_branch_outcome,
  input  logic               mem_misprediction,
  output logic [1:0]         mem_updated_prediction,
  output logic               pred_update_en,
  output logic               sweep_active,
  output logic [s_index-1:0] sweep_index,
  output logic               sweep_we,
  output logic               stall_if,
  output logic               flush_pipe,
  output logic [CNT_W-1:0]   branch_count,
  output logic [CNT_W-1:0]   mispredict_count
);

  localparam logic [s_index-1:0] IDX_LAST = '1;

  bp_state_t          state_q, state_d;
  logic [s_index-1:0] sweep_index_q, sweep_index_d;
  logic [CNT_W-1:0]   branch_count_q, branch_count_d;
  logic [CNT_W-1:0]   mispredict_count_q, mispredict_count_d;
  logic [1:0]         hit_next;
  logic               run;

  sat_counter2 u_sat (
    .cnt_in  (mem_predicted_branch_outcome),
    .taken   (mem_actual_branch_outcome),
    .cnt_out (hit_next)
  );

  always_comb begin
    run                    = (state_q == BP_RUN);
    pred_update_en         = run & mem_valid & (mem_is_branch | mem_BTB_hit);
    flush_pipe             = run & mem_valid & mem_misprediction;
    sweep_active           = ~run;
    sweep_we               = ~run;
    stall_if               = ~run;
    sweep_index            = sweep_index_q;
    branch_count           = branch_count_q;
    mispredict_count       = mispredict_count_q;
    mem_updated_prediction = 2'b00;
    if (run) begin
      if (mem_BTB_hit)
        mem_updated_prediction = hit_next;
      else if (mem_is_branch)
        mem_updated_prediction = mem_actual_branch_outcome ? BP_WEAK_TAKEN : BP_WEAK_NT;
    end
  end

  always_comb begin
    state_d            = state_q;
    sweep_index_d      = sweep_index_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    case (state_q)
      BP_SWEEP: begin
        if (flush_req) begin
          sweep_index_d = '0;
        end else if (sweep_index_q == IDX_LAST) begin
          sweep_index_d = '0;
          state_d       = BP_RUN;
        end else begin
          sweep_index_d = sweep_index_q + s_index'(1);
        end
      end
      BP_RUN: begin
        // The MEM-stage work of this cycle still retires when a flush starts a sweep
        if (mem_valid && mem_is_branch && !(&branch_count_q))
          branch_count_d = branch_count_q + CNT_W'(1);
        if (flush_pipe && !(&mispredict_count_q))
          mispredict_count_d = mispredict_count_q + CNT_W'(1);
        if (flush_req) begin
          state_d       = BP_SWEEP;
          sweep_index_d = '0;
        end
      end
      default: begin
        state_d       = BP_SWEEP;
        sweep_index_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= BP_SWEEP;
      sweep_index_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      state_q            <= state_d;
      sweep_index_q      <= sweep_index_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

endmodule
